// File: rtl/rs_encoder_16_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pkg
// Description : Shared constants, generator coefficients, FSM encoding and a
//               GF(2^8) multiply helper for the RS(16,8) encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int SYM_BW = 8;
    localparam int N_NUM  = 16;
    localparam int R_NUM  = 8;
    localparam int K_NUM  = N_NUM - R_NUM;

    localparam logic [SYM_BW:0] PRIM_POLY = 9'h11D;

    // Counter widths for message and parity positions
    localparam int MSG_CW = $clog2(K_NUM);
    localparam int PAR_CW = $clog2(R_NUM);

    // g(x) = prod_{i=0..7} (x - a^i), a = 0x02; GEN_COEF[i] is the x^i term.
    // The monic x^8 term is implicit.
    localparam logic [SYM_BW-1:0] GEN_COEF [R_NUM] = '{
        8'd24, 8'd200, 8'd173, 8'd239, 8'd54, 8'd81, 8'd11, 8'd255
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    // Shift-and-add multiply; each step multiplies the running term by a
    // and reduces modulo the field polynomial.
    function automatic logic [SYM_BW-1:0] gf_mul(input logic [SYM_BW-1:0] a,
                                                 input logic [SYM_BW-1:0] b);
        logic [SYM_BW-1:0] acc;
        logic [SYM_BW-1:0] sh;
        acc = '0;
        sh  = a;
        for (int j = 0; j < SYM_BW; j++) begin
            if (b[j]) acc = acc ^ sh;
            sh = {sh[SYM_BW-2:0], 1'b0} ^ (sh[SYM_BW-1] ? PRIM_POLY[SYM_BW-1:0] : '0);
        end
        return acc;
    endfunction

endpackage : rs_pkg
`default_nettype wire

// File: rtl/rs_encoder_16_8_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_encoder_16_8_if
// Description : Symbol-stream interface of the RS(16,8) encoder. The master
//               side supplies message symbols and flush; the slave side is
//               the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_encoder_16_8_if;

    logic                        flush;
    logic                        in_val;
    logic [rs_pkg::SYM_BW-1:0]   in_sym;
    logic                        in_rdy;
    logic                        out_val;
    logic [rs_pkg::SYM_BW-1:0]   out_sym;
    logic [rs_pkg::SYM_BW-1:0]   out_cnt;

    modport master (
        output flush, in_val, in_sym,
        input  in_rdy, out_val, out_sym, out_cnt
    );

    modport slave (
        input  flush, in_val, in_sym,
        output in_rdy, out_val, out_sym, out_cnt
    );

endinterface : rs_encoder_16_8_if
`default_nettype wire

// File: rtl/rs_encoder_16_8_gf_mul_const.sv
`default_nettype none
// ============================================================================
// Module      : gf_mul_const
// Description : Combinational GF(2^8) multiply of a symbol by a fixed
//               constant; synthesis folds it into an XOR network.
// Revision    : 1.0 - initial release
// ============================================================================
module gf_mul_const
    import rs_pkg::*;
#(
    parameter logic [SYM_BW-1:0] COEF = 8'h01
) (
    input  wire logic [SYM_BW-1:0] i_a,
    output logic      [SYM_BW-1:0] o_y
);

    // Product against the constant coefficient
    assign o_y = gf_mul(i_a, COEF);

endmodule : gf_mul_const
`default_nettype wire

// File: rtl/rs_encoder_16_8.sv
`default_nettype none
// ============================================================================
// Module      : rs_encoder_16_8
// Description : Systematic RS(16,8) encoder over GF(2^8). Passes the 8
//               message symbols through, then emits 8 parity symbols from a
//               division LFSR, highest-degree parity first.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_encoder_16_8
    import rs_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    rs_encoder_16_8_if.slave  bus
);

    state_t                r_state;
    logic [MSG_CW-1:0]     r_msg_cnt;
    logic [PAR_CW-1:0]     r_par_cnt;
    logic [SYM_BW-1:0]     r_par [R_NUM];
    logic                  r_out_val;
    logic [SYM_BW-1:0]     r_out_sym;
    logic [SYM_BW-1:0]     r_out_cnt;

    logic [SYM_BW-1:0]     w_fb;
    logic [SYM_BW-1:0]     w_prod [R_NUM];

    assign w_fb = bus.in_sym ^ r_par[R_NUM-1];

    for (genvar gi = 0; gi < R_NUM; gi++) begin : g_mul
        gf_mul_const #(
            .COEF (GEN_COEF[gi])
        ) u_mul (
            .i_a (w_fb),
            .o_y (w_prod[gi])
        );
    end

    // Ready depends on state only, so there is no input-to-output path here
    assign bus.in_rdy  = (r_state != ST_PAR);
    assign bus.out_val = r_out_val;
    assign bus.out_sym = r_out_sym;
    assign bus.out_cnt = r_out_cnt;

    // Block FSM, parity LFSR and registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_msg_cnt <= '0;
            r_par_cnt <= '0;
            r_out_val <= 1'b0;
            r_out_sym <= '0;
            r_out_cnt <= '0;
            for (int i = 0; i < R_NUM; i++) r_par[i] <= '0;
        end else if (bus.flush) begin
            // Abort wins over a concurrent symbol, which is dropped
            r_state   <= ST_IDLE;
            r_msg_cnt <= '0;
            r_par_cnt <= '0;
            r_out_val <= 1'b0;
            r_out_sym <= '0;
            r_out_cnt <= '0;
            for (int i = 0; i < R_NUM; i++) r_par[i] <= '0;
        end else begin
            r_out_val <= 1'b0;
            r_out_sym <= '0;
            r_out_cnt <= '0;
            case (r_state)
                ST_IDLE, ST_MSG: begin
                    if (bus.in_val) begin
                        r_out_val <= 1'b1;
                        r_out_sym <= bus.in_sym;
                        r_out_cnt <= SYM_BW'(r_msg_cnt) + SYM_BW'(1);
                        r_par[0]  <= w_prod[0];
                        for (int i = 1; i < R_NUM; i++) r_par[i] <= r_par[i-1] ^ w_prod[i];
                        if (r_msg_cnt == MSG_CW'(K_NUM - 1)) begin
                            r_state   <= ST_PAR;
                            r_msg_cnt <= '0;
                        end else begin
                            r_state   <= ST_MSG;
                            r_msg_cnt <= r_msg_cnt + MSG_CW'(1);
                        end
                    end
                end
                ST_PAR: begin
                    r_out_val <= 1'b1;
                    r_out_sym <= r_par[R_NUM-1];
                    r_out_cnt <= SYM_BW'(K_NUM + 1) + SYM_BW'(r_par_cnt);
                    r_par[0]  <= '0;
                    for (int i = 1; i < R_NUM; i++) r_par[i] <= r_par[i-1];
                    if (r_par_cnt == PAR_CW'(R_NUM - 1)) begin
                        r_state   <= ST_IDLE;
                        r_par_cnt <= '0;
                    end else begin
                        r_par_cnt <= r_par_cnt + PAR_CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : rs_encoder_16_8
`default_nettype wire
